// File: rtl/dvs_spinn_pkg.sv
// Shared types and helpers for the DVS UART to SpiNNaker bridge.
// Contents:
//   uart_state_e  - UART receiver states (START, DATA, STOP)
//   pair_state_e  - byte pairer states (HDR_WAIT, X_WAIT)
//   SPINN_PKT_W   - SpiNNaker multicast packet width (40)
//   KEY_W         - routing key width (32)
//   pkt_t         - packet layout {key, reserved, parity}
//   spinn_parity  - parity bit that makes the whole packet odd parity
package dvs_spinn_pkg;

  localparam int SPINN_PKT_W = 40;
  localparam int KEY_W       = 32;

  typedef enum logic [1:0] {
    UART_START = 2'd0,
    UART_DATA  = 2'd1,
    UART_STOP  = 2'd2
  } uart_state_e;

  typedef enum logic {
    PAIR_HDR_WAIT = 1'b0,
    PAIR_X_WAIT   = 1'b1
  } pair_state_e;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [6:0]       rsvd;
    logic             par;
  } pkt_t;

  // Takes packet bits [39:1]; the returned bit goes in bit 0.
  function automatic logic spinn_parity(input logic [SPINN_PKT_W-2:0] bits);
    return ~^bits;
  endfunction

endpackage

// File: rtl/spinn_pkt_fifo.sv
// Packet FIFO between the event pairer and the spinn_driver handshake.
// Ports:
//   clk_50, reset   - clock, async active-high reset (pointers only)
//   push_i, data_i  - write strobe (caller guarantees room or a same-cycle pop)
//   pop_i           - remove head (caller guarantees not empty)
//   full_o, empty_o - occupancy flags
//   head_o          - entry at the head, forced to 0 when empty
module spinn_pkt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 40
) (
  input  logic         clk_50,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d;
  logic [AW:0]  rd_q, rd_d;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty_o = (wr_q == rd_q);
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign head_o  = empty_o ? '0 : mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (push_i) wr_d = wr_q + 1'b1;
    if (pop_i)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  // When full, push and pop share a slot; the popped value is read before this edge.
  always_ff @(posedge clk_50) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/dvs_uart_spinn_bridge.sv
// UART (8N1) DVS event receiver that pairs bytes into (y, x) events, builds
// SpiNNaker multicast packets and queues them for spinn_driver.
// Ports:
//   clk_50, reset             - clock, async active-high reset
//   clken                     - oversample tick, OVERSAMPLE per UART bit
//   rx                        - UART line, idle high
//   is_receiving              - receiver is in its DATA state
//   spinn_pkt, ipkt_vld       - FIFO head packet and its valid
//   ipkt_rdy                  - downstream accept
//   dump                      - one-cycle pulse when a stalled head is dropped
//   frm_err_cnt, sync_err_cnt - bad stop bits / badly paired bytes
//   ovf_cnt, dump_cnt         - events lost to a full FIFO / heads dropped
module dvs_uart_spinn_bridge
  import dvs_spinn_pkg::*;
#(
  parameter int          OVERSAMPLE   = 16,
  parameter logic [15:0] CHIP_ADDR    = 16'h0005,
  parameter int          X_BITS       = 4,
  parameter int          Y_BITS       = 4,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          DUMP_TIMEOUT = 128,
  parameter int          CNT_W        = 16
) (
  input  logic                   clk_50,
  input  logic                   reset,
  input  logic                   clken,
  input  logic                   rx,
  output logic                   is_receiving,
  output logic [SPINN_PKT_W-1:0] spinn_pkt,
  output logic                   ipkt_vld,
  input  logic                   ipkt_rdy,
  output logic                   dump,
  output logic [CNT_W-1:0]       frm_err_cnt,
  output logic [CNT_W-1:0]       sync_err_cnt,
  output logic [CNT_W-1:0]       ovf_cnt,
  output logic [CNT_W-1:0]       dump_cnt
);

  localparam int             OS_W       = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST   = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID    = OS_W'(OVERSAMPLE / 2);
  localparam int             TMR_W      = (DUMP_TIMEOUT > 2) ? $clog2(DUMP_TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(DUMP_TIMEOUT - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // ---------------- UART receiver ----------------
  logic        rx_meta_q, rx_sync_q;
  uart_state_e uart_q, uart_d;
  logic [OS_W-1:0] os_q, os_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        byte_vld_q, byte_vld_d;
  logic        frm_err_stb;

  always_comb begin
    uart_d      = uart_q;
    os_d        = os_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    byte_vld_d  = 1'b0;
    frm_err_stb = 1'b0;
    if (clken) begin
      case (uart_q)
        UART_START: begin
          // Idle until the first low sample; a start bit gone high by
          // mid-bit is treated as a glitch and abandoned.
          if (os_q == '0 && rx_sync_q) begin
            os_d = '0;
          end else if (os_q == OS_MID && rx_sync_q) begin
            os_d = '0;
          end else if (os_q == OS_LAST) begin
            os_d   = '0;
            bit_d  = '0;
            uart_d = UART_DATA;
          end else begin
            os_d = os_q + 1'b1;
          end
        end
        UART_DATA: begin
          if (os_q == OS_MID) shift_d = {rx_sync_q, shift_q[7:1]};
          if (os_q == OS_LAST) begin
            os_d  = '0;
            bit_d = bit_q + 1'b1;
            if (bit_q == 3'd7) uart_d = UART_STOP;
          end else begin
            os_d = os_q + 1'b1;
          end
        end
        UART_STOP: begin
          // Returning to START at mid stop bit leaves half a bit of slack.
          if (os_q == OS_MID) begin
            os_d   = '0;
            uart_d = UART_START;
            if (rx_sync_q) byte_vld_d  = 1'b1;
            else           frm_err_stb = 1'b1;
          end else begin
            os_d = os_q + 1'b1;
          end
        end
        default: begin
          os_d   = '0;
          uart_d = UART_START;
        end
      endcase
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      uart_q     <= UART_START;
      os_q       <= '0;
      bit_q      <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      uart_q     <= uart_d;
      os_q       <= os_d;
      bit_q      <= bit_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  always_ff @(posedge clk_50) shift_q <= shift_d;

  assign is_receiving = (uart_q == UART_DATA);

  // ---------------- Byte pairer ----------------
  pair_state_e      pair_q, pair_d;
  logic [Y_BITS-1:0] y_q, y_d;
  logic             evt_vld_q, evt_vld_d;
  logic [14:0]      field_q, field_d;
  logic             sync_err_stb;

  always_comb begin
    pair_d       = pair_q;
    y_d          = y_q;
    evt_vld_d    = 1'b0;
    field_d      = field_q;
    sync_err_stb = 1'b0;
    if (byte_vld_q) begin
      case (pair_q)
        PAIR_HDR_WAIT: begin
          if (shift_q[7]) begin
            y_d    = shift_q[6 -: Y_BITS];
            pair_d = PAIR_X_WAIT;
          end else begin
            sync_err_stb = 1'b1;
          end
        end
        PAIR_X_WAIT: begin
          if (shift_q[7]) begin
            // A second header: keep the newest y and keep waiting for x.
            y_d          = shift_q[6 -: Y_BITS];
            sync_err_stb = 1'b1;
          end else begin
            evt_vld_d = 1'b1;
            field_d   = 15'({1'b0, y_q, shift_q[6 -: X_BITS]});
            pair_d    = PAIR_HDR_WAIT;
          end
        end
        default: pair_d = PAIR_HDR_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      pair_q    <= PAIR_HDR_WAIT;
      evt_vld_q <= 1'b0;
    end else begin
      pair_q    <= pair_d;
      evt_vld_q <= evt_vld_d;
    end
  end

  always_ff @(posedge clk_50) begin
    y_q     <= y_d;
    field_q <= field_d;
  end

  // ---------------- Packet build, FIFO, dump timer ----------------
  pkt_t pkt_new;
  logic [KEY_W-1:0] key_new;
  logic fifo_full, fifo_empty, push_ok, pop, hs, dump_fire, ovf_stb;
  logic [TMR_W-1:0] stall_q, stall_d;
  logic dump_q;

  assign key_new = {CHIP_ADDR, 1'b1, field_q};

  always_comb begin
    pkt_new.key  = key_new;
    pkt_new.rsvd = '0;
    pkt_new.par  = spinn_parity({key_new, 7'd0});
  end

  assign ipkt_vld  = !fifo_empty;
  assign hs        = ipkt_vld && ipkt_rdy;
  // rdy in the timeout cycle takes precedence: it is a normal pop.
  assign dump_fire = ipkt_vld && !ipkt_rdy && (stall_q == '0);
  assign pop       = hs || dump_fire;
  assign push_ok   = evt_vld_q && (!fifo_full || pop);
  assign ovf_stb   = evt_vld_q && fifo_full && !pop;

  always_comb begin
    if (!ipkt_vld || ipkt_rdy || dump_fire) stall_d = TMR_RELOAD;
    else                                    stall_d = stall_q - 1'b1;
  end

  spinn_pkt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (SPINN_PKT_W)
  ) u_fifo (
    .clk_50  (clk_50),
    .reset   (reset),
    .push_i  (push_ok),
    .data_i  (pkt_new),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (spinn_pkt)
  );

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      stall_q      <= TMR_RELOAD;
      dump_q       <= 1'b0;
      frm_err_cnt  <= '0;
      sync_err_cnt <= '0;
      ovf_cnt      <= '0;
      dump_cnt     <= '0;
    end else begin
      stall_q <= stall_d;
      dump_q  <= dump_fire;
      if (frm_err_stb)  frm_err_cnt  <= sat_inc(frm_err_cnt);
      if (sync_err_stb) sync_err_cnt <= sat_inc(sync_err_cnt);
      if (ovf_stb)      ovf_cnt      <= sat_inc(ovf_cnt);
      if (dump_fire)    dump_cnt     <= sat_inc(dump_cnt);
    end
  end

  assign dump = dump_q;

endmodule
